// File: rtl/fpu_stall_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_stall_if
// Purpose  : Handshake bundle between the EX-stage decode fields and the
//            multi-cycle FPU stall sequencer.
// Ports    : master - pipeline side (drives EX decode fields, reads status)
//            slave  - sequencer side (reads EX decode fields, drives status)
// Revision : 1.0  initial release
// ============================================================================
interface fpu_stall_if;
  // EX-stage decode fields
  logic       issue_valid;
  logic       fpu_stall_op;
  logic [3:0] alu_control;
  logic       fpu_reg_write;
  logic       reg_write;
  logic [4:0] rd;
  logic       flush;
  // sequencer status
  logic       stall;
  logic       fpu_start;
  logic       done;
  logic [4:0] done_rd;
  logic       done_fpr;
  logic       done_gpr;
  logic       busy;

  modport master (
    output issue_valid, fpu_stall_op, alu_control, fpu_reg_write,
           reg_write, rd, flush,
    input  stall, fpu_start, done, done_rd, done_fpr, done_gpr, busy
  );

  modport slave (
    input  issue_valid, fpu_stall_op, alu_control, fpu_reg_write,
           reg_write, rd, flush,
    output stall, fpu_start, done, done_rd, done_fpr, done_gpr, busy
  );
endinterface
`default_nettype wire

// File: rtl/fpu_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fpu_stall_ctrl
// Purpose  : Execute-stage sequencer for multi-cycle FPU ops. Holds the
//            pipeline for the op's latency, then pulses done for one cycle
//            with the captured writeback target. One op outstanding.
// Ports    : clk   - clock
//            rst   - synchronous active-high reset
//            bus_s - fpu_stall_if.slave: EX decode fields in
//                    (issue_valid, fpu_stall_op, alu_control, fpu_reg_write,
//                    reg_write, rd, flush); status out (stall, fpu_start,
//                    done, done_rd, done_fpr, done_gpr, busy)
// Revision : 1.0  initial release
// ============================================================================
module fpu_stall_ctrl #(
  parameter int unsigned LAT_DIV     = 8,
  parameter int unsigned LAT_SQRT    = 12,
  parameter int unsigned LAT_DEFAULT = 3,
  parameter logic [3:0]  OP_DIV      = 4'b0011,
  parameter logic [3:0]  OP_SQRT     = 4'b0100,
  parameter int unsigned CNT_W       = 5
) (
  input  wire logic  clk,
  input  wire logic  rst,
  fpu_stall_if.slave bus_s
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_LOAD_DIV  = CNT_W'(LAT_DIV - 1);
  localparam logic [CNT_W-1:0] C_LOAD_SQRT = CNT_W'(LAT_SQRT - 1);
  localparam logic [CNT_W-1:0] C_LOAD_DEF  = CNT_W'(LAT_DEFAULT - 1);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       rd_q;
  logic             fpr_q;
  logic             gpr_q;

  logic             accept_w;
  logic [CNT_W-1:0] load_w;

  // Reset gates accept so nothing is started or stalled while rst is high.
  assign accept_w = (state_q == S_IDLE) && !rst && bus_s.issue_valid &&
                    bus_s.fpu_stall_op && !bus_s.flush;

  always_comb begin
    load_w = C_LOAD_DEF;
    if (bus_s.alu_control == OP_DIV) begin
      load_w = C_LOAD_DIV;
    end else if (bus_s.alu_control == OP_SQRT) begin
      load_w = C_LOAD_SQRT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      fpr_q   <= 1'b0;
      gpr_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept_w) begin
            rd_q    <= bus_s.rd;
            fpr_q   <= bus_s.fpu_reg_write;
            gpr_q   <= bus_s.reg_write;
            cnt_q   <= load_w;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus_s.flush) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (cnt_q == C_ONE) begin
            // Last stalled cycle; counter parks at zero, never underflows.
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else begin
            cnt_q   <= cnt_q - C_ONE;
          end
        end
        // The completing op is still sitting in EX here, so DONE always
        // returns to IDLE without looking at issue_valid; flush is moot
        // because the result has already committed.
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_s.stall     = accept_w || (state_q == S_BUSY);
  assign bus_s.fpu_start = accept_w;
  assign bus_s.done      = (state_q == S_DONE);
  assign bus_s.busy      = (state_q != S_IDLE);
  assign bus_s.done_rd   = rd_q;
  assign bus_s.done_fpr  = fpr_q;
  assign bus_s.done_gpr  = gpr_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_stall_ctrl
// Purpose  : Self-checking bench for fpu_stall_ctrl: directed vector table,
//            hand-written multi-cycle sequences and random stimulus against
//            a cycle-age reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fpu_stall_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_stall_if bif ();

  fpu_stall_ctrl #(
    .LAT_DIV    (8),
    .LAT_SQRT   (12),
    .LAT_DEFAULT(3),
    .OP_DIV     (4'b0011),
    .OP_SQRT    (4'b0100),
    .CNT_W      (5)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus_s(bif.slave)
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic       op;
    logic [3:0] alu;
    logic       fpr;
    logic       gpr;
    logic [4:0] rd;
    logic       fl;
  } in_t;

  typedef struct {
    in_t        i;
    logic       stall;
    logic       start;
    logic       done;
    logic       busy;
    logic [4:0] drd;
    logic       dfpr;
    logic       dgpr;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference model: an op is described by the cycle it was accepted and its
  // total latency; everything else follows from its age.
  bit         m_active = 0;
  int         m_acc    = 0;
  int         m_lat    = 0;
  logic [4:0] m_rd     = '0;
  logic       m_fpr    = 1'b0;
  logic       m_gpr    = 1'b0;

  int st_q[$];
  int dn_q[$];
  int dnrd_q[$];
  int dngpr_q[$];
  int stall_q[$];
  int busy_q[$];

  function automatic int lat_of(logic [3:0] alu);
    if (alu == 4'b0011) return 8;
    if (alu == 4'b0100) return 12;
    return 3;
  endfunction

  function automatic in_t mk_in(logic r, logic iv, logic op, logic [3:0] alu,
                                logic fpr, logic gpr, logic [4:0] rd, logic fl);
    in_t x;
    x.rst = r; x.iv = iv; x.op = op; x.alu = alu;
    x.fpr = fpr; x.gpr = gpr; x.rd = rd; x.fl = fl;
    return x;
  endfunction

  function automatic vec_t mk_vec(in_t x, logic st, logic sr, logic dn, logic bz,
                                  logic [4:0] drd, logic dfpr, logic dgpr);
    vec_t v;
    v.i = x; v.stall = st; v.start = sr; v.done = dn; v.busy = bz;
    v.drd = drd; v.dfpr = dfpr; v.dgpr = dgpr;
    return v;
  endfunction

  function automatic int qget(int q[$], int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
  endtask

  task automatic clear_obs();
    st_q.delete(); dn_q.delete(); dnrd_q.delete(); dngpr_q.delete();
    stall_q.delete(); busy_q.delete();
  endtask

  // One clock: drive inputs, compare at negedge, advance model at posedge.
  task automatic step(input in_t x, input bit en, input bit use_tab, input vec_t v);
    int  age;
    bit  acc;
    bit  e_stall, e_done;
    rst               = x.rst;
    bif.issue_valid   = x.iv;
    bif.fpu_stall_op  = x.op;
    bif.alu_control   = x.alu;
    bif.fpu_reg_write = x.fpr;
    bif.reg_write     = x.gpr;
    bif.rd            = x.rd;
    bif.flush         = x.fl;
    @(negedge clk);
    age     = m_active ? (cyc - m_acc) : -1;
    acc     = !m_active && !x.rst && x.iv && x.op && !x.fl;
    e_done  = m_active && (age == m_lat);
    e_stall = (m_active && age < m_lat) || acc;
    if (en) begin
      chk("stall",     int'(bif.stall),     int'(e_stall));
      chk("fpu_start", int'(bif.fpu_start), int'(acc));
      chk("done",      int'(bif.done),      int'(e_done));
      chk("busy",      int'(bif.busy),      int'(m_active));
      chk("done_rd",   int'(bif.done_rd),   int'(m_rd));
      chk("done_fpr",  int'(bif.done_fpr),  int'(m_fpr));
      chk("done_gpr",  int'(bif.done_gpr),  int'(m_gpr));
    end
    if (use_tab) begin
      chk("tab_stall", int'(bif.stall),     int'(v.stall));
      chk("tab_start", int'(bif.fpu_start), int'(v.start));
      chk("tab_done",  int'(bif.done),      int'(v.done));
      chk("tab_busy",  int'(bif.busy),      int'(v.busy));
      chk("tab_rd",    int'(bif.done_rd),   int'(v.drd));
      chk("tab_fpr",   int'(bif.done_fpr),  int'(v.dfpr));
      chk("tab_gpr",   int'(bif.done_gpr),  int'(v.dgpr));
    end
    if (bif.fpu_start === 1'b1) st_q.push_back(cyc);
    if (bif.done === 1'b1) begin
      dn_q.push_back(cyc);
      dnrd_q.push_back(int'(bif.done_rd));
      dngpr_q.push_back(int'(bif.done_gpr));
    end
    stall_q.push_back(int'(bif.stall));
    busy_q.push_back(int'(bif.busy));
    @(posedge clk);
    if (x.rst) begin
      m_active = 0; m_rd = '0; m_fpr = 1'b0; m_gpr = 1'b0;
    end else if (m_active) begin
      if (age == m_lat || x.fl) m_active = 0;
    end else if (acc) begin
      m_active = 1; m_acc = cyc; m_lat = lat_of(x.alu);
      m_rd = x.rd; m_fpr = x.fpr; m_gpr = x.gpr;
    end
    cyc++;
    #1;
  endtask

  vec_t tab[12];
  vec_t none_v;

  initial begin
    in_t r_div, div, idle, x;
    int  base, cnt;

    r_div = mk_in(1, 1, 1, 4'b0011, 1, 0, 5'd7, 0);
    div   = mk_in(0, 1, 1, 4'b0011, 1, 0, 5'd7, 0);
    idle  = mk_in(0, 0, 0, 4'b0000, 0, 0, 5'd0, 0);
    none_v = mk_vec(idle, 0, 0, 0, 0, 5'd0, 0, 0);

    // Reset held 2 cycles with a stalling op present, then fdiv rd=7.
    tab[0]  = mk_vec(r_div, 0, 0, 0, 0, 5'd0, 0, 0);
    tab[1]  = mk_vec(r_div, 0, 0, 0, 0, 5'd0, 0, 0);
    tab[2]  = mk_vec(div,   1, 1, 0, 0, 5'd0, 0, 0);
    tab[3]  = mk_vec(div,   1, 0, 0, 1, 5'd7, 1, 0);
    tab[4]  = mk_vec(div,   1, 0, 0, 1, 5'd7, 1, 0);
    tab[5]  = mk_vec(div,   1, 0, 0, 1, 5'd7, 1, 0);
    tab[6]  = mk_vec(div,   1, 0, 0, 1, 5'd7, 1, 0);
    tab[7]  = mk_vec(div,   1, 0, 0, 1, 5'd7, 1, 0);
    tab[8]  = mk_vec(div,   1, 0, 0, 1, 5'd7, 1, 0);
    tab[9]  = mk_vec(div,   1, 0, 0, 1, 5'd7, 1, 0);
    tab[10] = mk_vec(div,   0, 0, 1, 1, 5'd7, 1, 0);
    tab[11] = mk_vec(idle,  0, 0, 0, 0, 5'd7, 1, 0);

    rst = 1'b1;
    bif.issue_valid = 0; bif.fpu_stall_op = 0; bif.alu_control = '0;
    bif.fpu_reg_write = 0; bif.reg_write = 0; bif.rd = '0; bif.flush = 0;
    @(posedge clk); #1;
    step(r_div, 0, 0, none_v);   // state before first edge is unknown

    for (int i = 0; i < 12; i++) step(tab[i].i, 1, 1, tab[i]);

    // Back-to-back: fsqrt rd=3, then default op rd=9 with reg_write.
    clear_obs(); base = cyc;
    for (int k = 0; k <= 12; k++) step(mk_in(0, 1, 1, 4'b0100, 1, 0, 5'd3, 0), 1, 0, none_v);
    for (int k = 13; k <= 16; k++) step(mk_in(0, 1, 1, 4'b0001, 0, 1, 5'd9, 0), 1, 0, none_v);
    step(idle, 1, 0, none_v);
    chk("b2b_starts",    st_q.size(), 2);
    chk("b2b_start2",    qget(st_q, 1) - base, 13);
    chk("b2b_done1",     qget(dn_q, 0) - base, 12);
    chk("b2b_done1_rd",  qget(dnrd_q, 0), 3);
    chk("b2b_done2",     qget(dn_q, 1) - base, 16);
    chk("b2b_done2_rd",  qget(dnrd_q, 1), 9);
    chk("b2b_done2_gpr", qget(dngpr_q, 1), 1);

    // Held issue: fdiv held 20 cycles restarts only from a fresh IDLE.
    clear_obs(); base = cyc;
    for (int k = 0; k < 20; k++) step(div, 1, 0, none_v);
    step(idle, 1, 0, none_v);
    step(idle, 1, 0, none_v);
    for (int k = 0; k < 10; k++) step(idle, 1, 0, none_v);
    chk("held_starts", st_q.size(), 3);
    chk("held_start0", qget(st_q, 0) - base, 0);
    chk("held_start1", qget(st_q, 1) - base, 9);
    chk("held_start2", qget(st_q, 2) - base, 18);

    // Flush in BUSY at cycle 3.
    clear_obs();
    for (int k = 0; k < 3; k++) step(div, 1, 0, none_v);
    step(mk_in(0, 1, 1, 4'b0011, 1, 0, 5'd7, 1), 1, 0, none_v);
    for (int k = 0; k < 12; k++) step(idle, 1, 0, none_v);
    chk("flush_stall3", qget(stall_q, 3), 1);
    chk("flush_stall4", qget(stall_q, 4), 0);
    chk("flush_busy4",  qget(busy_q, 4), 0);
    chk("flush_dones",  dn_q.size(), 0);

    // Non-stalling ops, then flush at issue.
    clear_obs();
    for (int k = 0; k < 5; k++) step(mk_in(0, 1, 0, 4'b0011, 1, 1, 5'd5, 0), 1, 0, none_v);
    for (int k = 0; k < 2; k++) step(mk_in(0, 1, 1, 4'b0011, 1, 1, 5'd5, 1), 1, 0, none_v);
    cnt = 0;
    foreach (stall_q[k]) cnt += stall_q[k] + busy_q[k];
    chk("nostall_stall_busy", cnt, 0);
    chk("nostall_starts", st_q.size(), 0);

    // Reset mid-operation.
    clear_obs();
    for (int k = 0; k < 4; k++) step(div, 1, 0, none_v);
    step(mk_in(1, 1, 1, 4'b0011, 1, 0, 5'd7, 0), 1, 0, none_v);
    for (int k = 0; k < 10; k++) step(idle, 1, 0, none_v);
    chk("rst_busy5", qget(busy_q, 5), 0);
    chk("rst_dones", dn_q.size(), 0);

    // Random stimulus against the model.
    for (int k = 0; k < 3000; k++) begin
      x.rst = ($urandom_range(0, 63) == 0);
      x.iv  = ($urandom_range(0, 3) != 0);
      x.op  = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 3))
        0: x.alu = 4'b0011;
        1: x.alu = 4'b0100;
        2: x.alu = 4'b0001;
        default: x.alu = 4'($urandom_range(0, 15));
      endcase
      x.fpr = $urandom_range(0, 1) != 0;
      x.gpr = $urandom_range(0, 1) != 0;
      x.rd  = 5'($urandom_range(0, 31));
      x.fl  = ($urandom_range(0, 15) == 0);
      step(x, 1, 0, none_v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpu_stall_ctrl.md
Name: fpu_stall_ctrl

Overview:
- Execute-stage sequencer for multi-cycle FPU ops (fdiv, fsqrt, other long ops) that the decoder flags via fpu_stall_op.
- Sits directly downstream of the instruction decoder: consumes fpu_stall_op, ALUControl, FPURegWrite, RegWrite and rd as latched into EX.
- Holds the pipeline for the op's latency, then emits a one-cycle completion pulse with writeback target.
- One op outstanding at a time; the FPU core is non-pipelined for these ops.

Parameters:
- LAT_DIV, 8, total cycles for ALUControl == OP_DIV (must be >= 2)
- LAT_SQRT, 12, total cycles for ALUControl == OP_SQRT (must be >= 2)
- LAT_DEFAULT, 3, total cycles for any other stalling op (must be >= 2)
- OP_DIV, 4'b0011, ALUControl code for fdiv
- OP_SQRT, 4'b0100, ALUControl code for fsqrt
- CNT_W, 5, width of latency counter; must hold max latency

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- issue_valid  in  1  valid instruction present in EX this cycle
- fpu_stall_op  in  1  decoder flag: EX op is multi-cycle FPU
- alu_control  in  4  decoder ALUControl of EX op
- fpu_reg_write  in  1  decoder FPURegWrite of EX op
- reg_write  in  1  decoder RegWrite of EX op
- rd  in  5  destination register of EX op
- flush  in  1  kill EX op (branch/jump redirect)
- stall  out  1  freeze IF/ID/EX; combinational
- fpu_start  out  1  one-cycle start strobe to FPU core
- done  out  1  one-cycle completion pulse
- done_rd  out  5  captured rd, valid with done
- done_fpr  out  1  captured fpu_reg_write, valid with done
- done_gpr  out  1  captured reg_write, valid with done
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, BUSY, DONE. Reset: IDLE, counter 0, all captured fields 0; every output 0.
- accept = IDLE & issue_valid & fpu_stall_op & ~flush.
- L = LAT_DIV if alu_control == OP_DIV, LAT_SQRT if == OP_SQRT, else LAT_DEFAULT.
- Accept cycle (cycle 0):
  - fpu_start = 1 and stall = 1 (combinationally from accept).
  - Capture rd, fpu_reg_write, reg_write.
  - Load counter with L-1; next state BUSY.
- BUSY:
  - stall = 1; counter decrements each cycle.
  - When counter == 1, next state is DONE.
  - Result: stall is high for exactly cycles 0..L-1.
- DONE (cycle L):
  - done = 1 with captured fields; stall = 0 so the pipeline advances.
  - Next state is IDLE unconditionally.
  - No accept occurs in DONE. The completing op is still in EX with issue_valid/fpu_stall_op high, and must not be re-issued.
- Back-to-back stalling ops: the second one enters EX at cycle L+1 (IDLE) and is accepted then. Gap between fpu_start pulses = L+1.
- Non-stalling ops (fpu_stall_op = 0) never leave IDLE and never assert stall.
- issue_valid = 0 with fpu_stall_op = 1 (bubble carrying stale decode): no accept.
- flush:
  - In IDLE, flush suppresses accept.
  - In BUSY, flush forces next state IDLE, clears the counter and raises no done. stall stays asserted that cycle (combinational from BUSY) and drops next cycle.
  - In DONE, flush is ignored; done still pulses (the op already committed).
- rst mid-operation: next cycle IDLE, outputs 0, no done.
- done_rd/done_fpr/done_gpr hold their last captured value outside done; consumers qualify with done.
- Counter arithmetic unsigned CNT_W bits; never underflows (decrement only while BUSY with counter >= 2).

Test Plan:
- Reset then idle: rst high 2 cycles with issue_valid=1, fpu_stall_op=1 -> stall=0, done=0, busy=0 throughout reset. First accept occurs the cycle after rst drops.
- fdiv: alu_control=4'b0011, rd=7, fpu_reg_write=1 accepted at cycle 0 -> fpu_start at 0 only; stall high cycles 0..7; done=1, done_rd=7, done_fpr=1, done_gpr=0 at cycle 8; busy low at cycle 9.
- Back-to-back: fsqrt (4'b0100, rd=3) at cycle 0, then default op (4'b0001, rd=9, reg_write=1) held in EX from cycle 13 -> done rd=3 at cycle 12; second fpu_start at cycle 13; second done rd=9, done_gpr=1 at cycle 16.
- Held issue: keep issue_valid=1 and fpu_stall_op=1 constant for 20 cycles with fdiv -> exactly one fpu_start at cycle 0; second start at cycle 9 (fresh IDLE); never in DONE cycle 8.
- Flush in BUSY: fdiv accepted at cycle 0, flush=1 at cycle 3 -> stall high cycles 0..3, low at 4; no done pulse ever; busy=0 at cycle 4.
- Non-stalling and flush-at-issue: fpu_stall_op=0 for 5 cycles -> stall never high. Then fpu_stall_op=1 with flush=1 -> no fpu_start, state stays IDLE.
